// File: rtl/dac_subsystem.sv
// Millivolt setpoint to PWM DAC: clamp, fixed-point reciprocal scaling, and
// period-synchronous duty updates. Optional slew limiting under DAC_SLEW_EN.
module dac_subsystem #(
  parameter int PWM_BITS      = 12,
  parameter int FULL_SCALE_MV = 3300,
  parameter int SLEW_STEP     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         mv_in,
  input  logic                mv_valid,
  output logic                mv_ready,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] dac_code,
  output logic                period_tick
);

  localparam logic [PWM_BITS-1:0] CODE_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_LAST = CODE_MAX - 1'b1;
  localparam logic [15:0]         FS_MV    = 16'(FULL_SCALE_MV);

  // Reciprocal of full scale in Q16, so code = mv * RECIP / 2^16 (rounded).
  localparam longint unsigned RECIP_L =
    ((((64'd1 << PWM_BITS) - 64'd1)) << 16) / 64'(FULL_SCALE_MV);
  localparam int RECIP_W = ($clog2(RECIP_L + 1) > 18) ? $clog2(RECIP_L + 1) : 18;
  localparam int PROD_W  = 16 + RECIP_W;
  localparam logic [RECIP_W-1:0] RECIP = RECIP_W'(RECIP_L);
  localparam logic [PROD_W:0]    ROUND = (PROD_W + 1)'(32768);

  typedef enum logic [1:0] {IDLE, CLAMP, MUL, LOAD} state_t;

  state_t              state;
  logic [15:0]         mv_reg;
  logic [15:0]         clamp_reg;
  logic [PROD_W-1:0]   prod_reg;
  logic [PWM_BITS-1:0] pending_reg;
  logic [PWM_BITS-1:0] cnt_reg;

  logic [PROD_W:0]     code_full;
  logic [PWM_BITS-1:0] code_sat;
  logic [PWM_BITS-1:0] cnt_next;
  logic [PWM_BITS-1:0] active_next;
  logic [PWM_BITS-1:0] boundary_code;
  logic                boundary;

  assign code_full = ({1'b0, prod_reg} + ROUND) >> 16;
  assign code_sat  = (code_full > (PROD_W + 1)'(CODE_MAX)) ? CODE_MAX
                                                           : code_full[PWM_BITS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      mv_ready    <= 1'b1;
      mv_reg      <= '0;
      clamp_reg   <= '0;
      prod_reg    <= '0;
      pending_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mv_valid) begin
            mv_reg   <= mv_in;
            mv_ready <= 1'b0;
            state    <= CLAMP;
          end
        end
        CLAMP: begin
          clamp_reg <= (mv_reg > FS_MV) ? FS_MV : mv_reg;
          state     <= MUL;
        end
        MUL: begin
          prod_reg <= PROD_W'(clamp_reg) * PROD_W'(RECIP);
          state    <= LOAD;
        end
        default: begin
          pending_reg <= code_sat;
          mv_ready    <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef DAC_SLEW_EN
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(SLEW_STEP);
  always_comb begin
    boundary_code = dac_code;
    if (pending_reg > dac_code) begin
      boundary_code = ((pending_reg - dac_code) > STEP) ? (dac_code + STEP) : pending_reg;
    end else if (pending_reg < dac_code) begin
      boundary_code = ((dac_code - pending_reg) > STEP) ? (dac_code - STEP) : pending_reg;
    end
  end
`else
  assign boundary_code = pending_reg;
`endif

  assign boundary    = (cnt_reg == CNT_LAST);
  assign cnt_next    = boundary ? '0 : (cnt_reg + 1'b1);
  // The pending register is sampled pre-edge, so a LOAD landing on the
  // boundary edge waits for the following period.
  assign active_next = boundary ? boundary_code : dac_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      dac_code    <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      dac_code    <= active_next;
      pwm_out     <= (cnt_next < active_next);
      period_tick <= (cnt_next == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_dac_subsystem.sv
// Scoreboard bench for dac_subsystem: stimulus queues the dac_code expected at
// each period boundary; a monitor pops, compares, and checks per-period duty.
`timescale 1ns/1ps
module tb_dac_subsystem;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mv_in = '0;
  logic        mv_valid = 1'b0;
  logic        mv_ready;
  logic        pwm_out;
  logic [11:0] dac_code;
  logic        period_tick;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  bit          mon_cmp = 1'b0;
  bit          duty_known = 1'b0;
  int          hi_cnt = 0;
  logic [11:0] duty_exp = '0;

  logic [15:0] hs_vals [8] = '{16'd3300, 16'd500, 16'd2500, 16'd100,
                               16'd1000, 16'd3000, 16'd200, 16'd1650};

  always #5 clk = ~clk;

  dac_subsystem dut (
    .clk         (clk),
    .reset       (reset),
    .mv_in       (mv_in),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .pwm_out     (pwm_out),
    .dac_code    (dac_code),
    .period_tick (period_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: compare dac_code on the first cycle of each new period.
  always @(negedge clk) begin
    if (!reset) begin
      hi_cnt     = 0;
      mon_cmp    = 1'b0;
      duty_known = 1'b0;
    end else begin
      if (mon_cmp) begin
        mon_cmp = 1'b0;
        if (exp_q.size() > 0) begin
          duty_exp = exp_q.pop_front();
          check("dac_code_at_boundary", dac_code, duty_exp);
          $display("boundary: dac_code=%0d expected=%0d", dac_code, duty_exp);
          duty_known = 1'b1;
        end else begin
          duty_known = 1'b0;
        end
      end
      hi_cnt += pwm_out;
      if (period_tick) begin
        if (duty_known) check("duty_high_clocks", hi_cnt, duty_exp);
        hi_cnt  = 0;
        mon_cmp = 1'b1;
      end
    end
  end

  task automatic send(input logic [15:0] mv);
    check("mv_ready_before_send", mv_ready, 1);
    mv_in    = mv;
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("mv_ready_busy", mv_ready, 0);
      @(negedge clk);
    end
    check("mv_ready_after_load", mv_ready, 1);
    $display("setpoint: %0d mV accepted", mv);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 5000);
    check("wait_tick_timeout", period_tick, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic release_and_time();
    int n = 0;
    reset = 1'b1;
    check("rst_mv_ready", mv_ready, 1);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_dac_code", dac_code, 0);
    check("rst_period_tick", period_tick, 0);
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 5000);
    check("first_tick_clocks", n, 4094);
    $display("reset release: first period_tick after %0d clocks", n);
  endtask

  task automatic apply(input logic [15:0] mv, input logic [11:0] code);
    exp_q.push_back(code);
    send(mv);
    wait_drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("in_reset_mv_ready", mv_ready, 1);
    check("in_reset_dac_code", dac_code, 0);
    release_and_time();
    repeat (2) @(negedge clk);

    // Scaling, clamp, and duty extremes.
    apply(16'd0,    12'd0);
    apply(16'd1000, 12'd1241);
    apply(16'd1650, 12'd2047);
    apply(16'd3300, 12'd4095);
    apply(16'd5000, 12'd4095);

    // Held valid with changing data: only every 4th offer is taken.
    exp_q.push_back(12'd1241);
    for (int i = 0; i < 8; i++) begin
      check("hs_mv_ready", mv_ready, (i % 4 == 0) ? 1 : 0);
      mv_in    = hs_vals[i];
      mv_valid = 1'b1;
      @(negedge clk);
    end
    mv_valid = 1'b0;
    check("hs_mv_ready_end", mv_ready, 1);
    $display("handshake: 8 offers held, last accepted 1000 mV");
    wait_drain();

    // LOAD lands exactly on the boundary edge.
    wait_tick();
    repeat (4092) @(negedge clk);
    exp_q.push_back(12'd1241);
    exp_q.push_back(12'd2000);
    send(16'd1612);
    wait_drain();

    // Reset while the multiply is in flight.
    mv_in    = 16'd3300;
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_dac_code", dac_code, 0);
    check("mid_reset_mv_ready", mv_ready, 1);
    @(negedge clk);
    exp_q.push_back(12'd0);
    release_and_time();
    wait_drain();
    wait_tick();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_subsystem.md
# dac_subsystem

Output-side counterpart of the ADC capture path: accepts a millivolt setpoint (0–3300 mV, same scale the ADC path reports), converts it to a PWM duty code and drives a single PWM pin that feeds an external RC filter. It sits between the control/display logic and a PMOD output pin. Duty updates are glitch-free: a new code takes effect only at a PWM period boundary.

## Interface
- `PWM_BITS`, 12: duty-code width; PWM period is 2**PWM_BITS−1 clocks.
- `FULL_SCALE_MV`, 3300: millivolt value mapped to full-scale code.
- `SLEW_STEP`, 64: maximum code change per period; used only with `DAC_SLEW_EN`.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mv_in` input 16: setpoint in millivolts, unsigned.
- `mv_valid` input 1: `mv_in` valid this cycle.
- `mv_ready` output 1: block can accept a setpoint.
- `pwm_out` output 1: PWM output, registered.
- `dac_code` output PWM_BITS: duty code currently applied (active code).
- `period_tick` output 1: one-clock pulse on the last cycle of each PWM period.

## Operation
- Reset (`reset`=0, async): all outputs and internal registers cleared; `mv_ready`=1, `pwm_out`=0, `dac_code`=0, `period_tick`=0, PWM counter=0, pending code=0, FSM=IDLE.
- Handshake: transfer when `mv_valid` && `mv_ready` at a rising edge. `mv_ready`=1 only in IDLE. `mv_valid` while `mv_ready`=0 is ignored (no buffering).
- FSM: IDLE → CLAMP (on transfer) → MUL → LOAD → IDLE; one cycle per non-IDLE state.
  - CLAMP: register min(`mv_in`, FULL_SCALE_MV).
  - MUL: register product clamped × RECIP, RECIP = floor(((2**PWM_BITS−1)·2**16)/FULL_SCALE_MV), elaboration-time constant (81324 at defaults); product width 16+18 bits minimum, no truncation.
  - LOAD: pending code = (product + 2**15) >> 16, saturated to 2**PWM_BITS−1.
- PWM counter: counts 0 … 2**PWM_BITS−2, wraps to 0. `pwm_out` registered from (counter < active code). Code 0 → constantly low; code 2**PWM_BITS−1 → constantly high.
- Period boundary (counter = 2**PWM_BITS−2): `period_tick`=1; at that edge active code ← pending code (as held before the edge).
- Simultaneous LOAD and boundary in same cycle: active code takes the old pending value; the new value applies at the next boundary.
- Repeated setpoints before a boundary: last completed LOAD wins.
- Reset mid-conversion: in-flight setpoint discarded, no partial update.

## Timing
- Accept → pending code: 3 clocks (end of LOAD). `mv_ready` low for those 3 clocks, high again the cycle after LOAD; max throughput one setpoint per 4 clocks.
- Pending → `dac_code`: at the next period boundary, 1 to 2**PWM_BITS−1 clocks.
- `dac_code` → `pwm_out`: first cycle of the new period reflects new code (counter=0 compare registered at that edge).
- `period_tick` period: exactly 2**PWM_BITS−1 clocks (4095 at defaults), first tick 4094 clocks after reset release.

## Configuration
- `DAC_SLEW_EN` defined: at each boundary active code moves toward pending code by min(|pending−active|, SLEW_STEP); never overshoots; equal codes → no change.
- Undefined: active code loads pending code directly at each boundary; `SLEW_STEP` unused.

## Test plan
- Reset: hold `reset`=0 mid-period, release → `mv_ready`=1, `pwm_out`=0, `dac_code`=0, first `period_tick` after 4094 clocks.
- Scaling: send 0, 1000, 1650, 3300, 5000 mV → pending/`dac_code` 0, 1241, 2047, 4095, 4095 (clamp); 4095 gives `pwm_out` high for the whole period, 0 gives low.
- Duty: `dac_code`=1241 → exactly 1241 high clocks per 4095-clock period, high at period start.
- Handshake: hold `mv_valid`=1 with changing `mv_in` → accepts only every 4th clock; values offered while `mv_ready`=0 never appear on `dac_code`.
- Boundary race: LOAD of 2000 coinciding with `period_tick` → `dac_code` keeps old value this period, becomes 2000 at next boundary; reset asserted during MUL → `dac_code` 0, setpoint lost.
- `DAC_SLEW_EN`: from 0, setpoint 3300 mV → `dac_code` 64, 128, … per period, reaching 4095 after 64 periods; without macro → 4095 at first boundary.
